// File: rtl/sdr_fifo_pkg.sv
// Shared constants and helpers for the SDR sample FIFO.
//   DW_DEF / AW_DEF / AF_LEVEL_DEF : default data width, address width and
//                                    almost-full threshold.
//   ERR_*_BIT                      : bit positions of the sticky error flags
//                                    in the diagnostic error register.
//   fifo_depth()                   : number of entries for a given address width.
package sdr_fifo_pkg;

  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 4;
  localparam int AF_LEVEL_DEF = 12;

  // Diagnostic register map: error flag positions.
  localparam int ERR_OVF_BIT  = 0;
  localparam int ERR_UDF_BIT  = 1;
  localparam int ERR_W        = 2;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sdr_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i      : read enable / address; data appears on rdata_o
//                        one clock later and holds while re_i is low
//   rdata_o            : registered read data
module sdr_fifo_ram
  import sdr_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(AW);

  // Storage has no reset so it stays inferable as RAM.
  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register resets to zero and holds between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdr_sample_fifo.sv
// Synchronous sample FIFO with registered occupancy and diagnostic flags.
// Optional feature macro: SDR_FIFO_PEAK_EN (adds peak_level high-water mark).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, wr_data      : write request and data
//   rd_en               : read request
//   rd_data, rd_valid   : registered read data, one-cycle valid pulse
//   full, empty         : level == depth / level == 0
//   almost_full         : level >= AF_LEVEL
//   level               : occupancy 0..depth
//   overflow, underflow : sticky error flags, cleared by clr_err (set wins)
//   peak_level          : (SDR_FIFO_PEAK_EN only) highest level seen
module sdr_sample_fifo
  import sdr_fifo_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
`ifdef SDR_FIFO_PEAK_EN
  ,
  output logic [AW:0]   peak_level
`endif
);

  localparam int          DEPTH     = fifo_depth(AW);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_LEVEL);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q, af_q;
  logic             rd_valid_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             wr_acc, rd_acc;

  // Read is judged first: a write into a full FIFO is allowed only
  // when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = wr_en & (~full_q | rd_acc);

  assign level_d = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = '0;
    end
    // Error events override a coincident clear.
    if (wr_en & ~wr_acc) begin
      err_d[ERR_OVF_BIT] = 1'b1;
    end
    if (rd_en & ~rd_acc) begin
      err_d[ERR_UDF_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q    <= level_d;
      // Flags come from the next level so they are exact after the edge.
      full_q     <= (level_d == DEPTH_LVL);
      empty_q    <= (level_d == '0);
      af_q       <= (level_d >= AF_LVL);
      rd_valid_q <= rd_acc;
      err_q      <= err_d;
    end
  end

  sdr_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef SDR_FIFO_PEAK_EN
  logic [AW:0] peak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (clr_err) begin
      peak_q <= level_d;
    end else if (level_d > peak_q) begin
      peak_q <= level_d;
    end
  end

  assign peak_level = peak_q;
`endif

  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = err_q[ERR_OVF_BIT];
  assign underflow   = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_sdr_sample_fifo.sv
module tb_sdr_sample_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, overflow, underflow;
  logic [4:0] level;
`ifdef SDR_FIFO_PEAK_EN
  logic [4:0] peak_level;
`endif

  sdr_sample_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef SDR_FIFO_PEAK_EN
    ,
    .peak_level  (peak_level)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a plain queue plus the expected registered outputs.
  logic [7:0] mq[$];
  logic [7:0] m_rdata;
  logic       m_valid, m_ovf, m_udf;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"},     int'(level),       mq.size());
    chk({tag, ".full"},      int'(full),        int'(mq.size() == 16));
    chk({tag, ".empty"},     int'(empty),       int'(mq.size() == 0));
    chk({tag, ".afull"},     int'(almost_full), int'(mq.size() >= 12));
    chk({tag, ".rd_valid"},  int'(rd_valid),    int'(m_valid));
    chk({tag, ".rd_data"},   int'(rd_data),     int'(m_rdata));
    chk({tag, ".overflow"},  int'(overflow),    int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow),   int'(m_udf));
  endtask

  // One clock of stimulus: model advanced from pre-edge state, DUT sampled #1 after edge.
  task automatic apply(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input string tag);
    bit rd_ok, wr_ok;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < 16) || rd_ok);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && !rd_ok) m_udf = 1'b1;
    m_valid = rd_ok;
    if (rd_ok) m_rdata = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    check_model(tag);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic [4:0] lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       vld;
    logic [7:0] rdd;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t v;
    logic [7:0] last;

    // Directed table: idle, 16 writes, overflow write, 16 reads, underflow read.
    v = '{0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 0, 8'h00, 0, 0};
    vt.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = '{1, 8'(i + 1), 0, 0, 5'(i + 1), (i == 15), 0, (i + 1 >= 12), 0, 8'h00, 0, 0};
      vt.push_back(v);
    end
    v = '{1, 8'hAA, 0, 0, 5'd16, 1, 0, 1, 0, 8'h00, 1, 0};
    vt.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = '{0, 8'h00, 1, 0, 5'(15 - i), 0, (i == 15), (15 - i >= 12), 1, 8'(i + 1), 1, 0};
      vt.push_back(v);
    end
    v = '{0, 8'h00, 1, 0, 5'd0, 0, 1, 0, 0, 8'h10, 1, 1};
    vt.push_back(v);

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      apply(vt[i].wr, vt[i].wd, vt[i].rd, vt[i].clr, "tbl");
      chk("tbl.level",  int'(level),       int'(vt[i].lvl));
      chk("tbl.full",   int'(full),        int'(vt[i].full));
      chk("tbl.empty",  int'(empty),       int'(vt[i].empty));
      chk("tbl.afull",  int'(almost_full), int'(vt[i].af));
      chk("tbl.valid",  int'(rd_valid),    int'(vt[i].vld));
      chk("tbl.rdata",  int'(rd_data),     int'(vt[i].rdd));
      chk("tbl.ovf",    int'(overflow),    int'(vt[i].ovf));
      chk("tbl.udf",    int'(underflow),   int'(vt[i].udf));
      $display("vec %0d: wr=%0b wd=%02h rd=%0b clr=%0b -> level=%0d valid=%0b rdata=%02h ovf=%0b udf=%0b",
               i, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].clr, level, rd_valid, rd_data,
               overflow, underflow);
    end

    // Simultaneous write/read while full.
    apply(0, 8'h00, 0, 1, "clr");
    for (int i = 0; i < 16; i++) apply(1, 8'(8'h20 + i), 0, 0, "fill");
    apply(1, 8'h55, 1, 0, "fullwr");
    chk("fullwr.level", int'(level), 16);
    chk("fullwr.ovf",   int'(overflow), 0);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      apply(0, 8'h00, 1, 0, "drain55");
      last = rd_data;
    end
    chk("drain55.last", int'(last), 8'h55);
    $display("seq full-wr/rd: last read %02h", last);

    // Pointer wrap at constant level 3.
    for (int i = 0; i < 3; i++) apply(1, 8'($urandom), 0, 0, "pre");
    for (int i = 0; i < 40; i++) begin
      apply(1, 8'($urandom), 1, 0, "wrap");
      chk("wrap.level3", int'(level), 3);
    end
    for (int i = 0; i < 3; i++) apply(0, 8'h00, 1, 0, "post");
    $display("seq wrap: level=%0d empty=%0b", level, empty);

    // Error flags: set both, then clear coincident with a new underflow.
    apply(0, 8'h00, 1, 0, "udf");
    for (int i = 0; i < 16; i++) apply(1, 8'(i), 0, 0, "fill2");
    apply(1, 8'hEE, 0, 0, "ovf");
    for (int i = 0; i < 16; i++) apply(0, 8'h00, 1, 0, "drain2");
    chk("both.ovf", int'(overflow), 1);
    chk("both.udf", int'(underflow), 1);
    apply(0, 8'h00, 1, 1, "clrudf");
    chk("clrudf.udf", int'(underflow), 1);
    chk("clrudf.ovf", int'(overflow), 0);
    $display("seq clr+err: ovf=%0b udf=%0b", overflow, underflow);

    // Reset during a burst: outputs return to reset values before the next edge.
    for (int i = 0; i < 6; i++) apply(1, 8'(8'h70 + i), (i > 2), 0, "burst");
    apply(1, 8'h99, 1, 0, "burst");
    rst = 1'b1;
    #2;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("post_rst");
    $display("seq reset: level=%0d valid=%0b empty=%0b", level, rd_valid, empty);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      logic w, r, c;
      int bias;
      bias = (i / 250) % 2 == 0 ? 3 : 1;
      w = ($urandom_range(0, 3) < bias);
      r = ($urandom_range(0, 3) < 4 - bias);
      c = ($urandom_range(0, 31) == 0);
      apply(w, 8'($urandom), r, c, "rand");
    end
    $display("seq random: 2000 cycles, final level=%0d", level);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdr_sample_fifo.md
Name: sdr_sample_fifo

Overview:
Synchronous byte/sample FIFO sitting directly upstream of the FIFO-status UART reporter. Its full and empty flags feed that reporter's full/empty inputs. It also buffers SDR samples between producer and consumer logic in the same clock domain. It adds registered occupancy, almost-full, and sticky overflow/underflow error flags for diagnostics.

Parameters:
DW, 8, data width in bits
AW, 4, address width; depth = 2**AW entries (16)
AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL (must be <= 2**AW)

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request, sampled each clk
wr_data  in  DW  write data
rd_en  in  1  read request, sampled each clk
rd_data  out  DW  read data, registered
rd_valid  out  1  one-cycle pulse; rd_data is valid in this cycle
full  out  1  level == 2**AW
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
level  out  AW+1  current occupancy, 0..2**AW
overflow  out  1  sticky: a write was attempted while full and not accepted
underflow  out  1  sticky: a read was attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset, asynchronous active-high (single clock clk): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. RAM contents are don't-care.
- Pointers are AW bits wide and wrap modulo 2**AW. The pointer after 2**AW-1 is 0.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & (~full | rd_acc).
  - rd_acc = rd_en & ~empty.
  - A simultaneous write and read while full is accepted; level stays 2**AW.
  - A simultaneous write and read while empty: write accepted, read rejected, underflow set, level goes to 1.
- Level update: level <= level + wr_acc - rd_acc.
  - full, empty, and almost_full are registered and derived from the next level value, so they are exact in the cycle after the edge.
- Read latency is 1 cycle. On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next edge; otherwise rd_valid <= 0 and rd_data holds its value.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr advances. A read of the same entry in the same cycle is impossible, because that entry is not yet counted in level.
- Error flags:
  - overflow <= 1 on wr_en & ~wr_acc.
  - underflow <= 1 on rd_en & ~rd_acc.
  - clr_err clears both. If clr_err coincides with a new error event, set wins.
- Reset mid-operation discards all contents immediately. rd_valid drops asynchronously.
- The block has no FSM beyond pointers and counters. All outputs are registered.

Optional Feature:
Macro name: SDR_FIFO_PEAK_EN.
- When defined: adds output peak_level [AW:0], a high-water mark.
  - peak_level <= max(peak_level, next level) each cycle.
  - It resets to 0 and is cleared to the current level by clr_err.
- When not defined: the port and register are absent, and behaviour is otherwise identical.

Decomposition:
- Package sdr_fifo_pkg holds:
  - default DW/AW/AF_LEVEL constants;
  - a function computing depth from AW;
  - an error-flag bit-index constant for the diagnostic register map.
- Sub-module sdr_fifo_ram: a simple dual-port RAM with one write port and one registered read port. It is inferable as distributed or block RAM.
- Pointer, level, and flag logic stay in the top block.

Test Plan:
- Reset then idle -> empty=1, full=0, level=0, rd_valid=0, overflow=underflow=0.
- Write 0x01..0x10 (16 writes) -> full=1 after the 16th edge and almost_full=1 from level 12. A 17th write of 0xAA -> overflow=1, level stays 16, and 0xAA is never read.
- Read 16 entries -> rd_data sequence 0x01..0x10, each with rd_valid one cycle after rd_en. empty=1 at the end. A further read -> underflow=1 and no rd_valid.
- When full, simultaneous wr_en (0x55) and rd_en -> level stays 16 with no overflow. The next 16 reads end with 0x55.
- Pointer wrap: 40 interleaved write/read pairs at level 3 -> data order preserved across the wrap at 15->0, and level constant at 3.
- Error flags: set both, then assert clr_err together with a new rd_en while empty -> underflow stays 1, overflow clears. Assert rst during a burst -> all outputs return to reset values before the next edge.
